// File: rtl/mips_branch_pkg.sv
// Shared branch-unit encodings for the MIPS EX-stage resolver.
// Compare modes and predictor counter constants.
package mips_branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'd0,
    BR_BNE    = 3'd1,
    BR_BLEZ   = 3'd2,
    BR_BGTZ   = 3'd3,
    BR_BLTZ   = 3'd4,
    BR_BGEZ   = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_NONE   = 3'd7
  } br_op_e;

  localparam logic [1:0] BHT_WEAK_NT = 2'b01;
  localparam logic [1:0] BHT_STRONG_T = 2'b11;
  localparam logic [1:0] BHT_STRONG_NT = 2'b00;

endpackage

// File: rtl/branch_resolve_predict_if.sv
// Pipeline-facing bundle of the branch resolve/predict unit.
// master = pipeline side, slave = branch unit.
interface branch_resolve_predict_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic [DATA_WIDTH-1:0] FetchPC;
  logic                  PredTaken;
  logic                  ResValid;
  logic                  Branch;
  logic [2:0]            BranchOp;
  logic [DATA_WIDTH-1:0] OperandA;
  logic [DATA_WIDTH-1:0] OperandB;
  logic [DATA_WIDTH-1:0] ResPC;
  logic [DATA_WIDTH-1:0] ResTarget;
  logic                  ResPredTaken;
  logic                  Stall;
  logic                  PCSrc;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] RedirectPC;
  logic [CNT_WIDTH-1:0]  BranchCount;
  logic [CNT_WIDTH-1:0]  MispredCount;

  modport master (
    output FetchPC, ResValid, Branch, BranchOp,
    output OperandA, OperandB, ResPC, ResTarget,
    output ResPredTaken, Stall,
    input  PredTaken, PCSrc, Flush, RedirectPC,
    input  BranchCount, MispredCount
  );

  modport slave (
    input  FetchPC, ResValid, Branch, BranchOp,
    input  OperandA, OperandB, ResPC, ResTarget,
    input  ResPredTaken, Stall,
    output PredTaken, PCSrc, Flush, RedirectPC,
    output BranchCount, MispredCount
  );

endinterface

// File: rtl/branch_resolve_predict_sat_counter2.sv
// 2-bit saturating up/down counter, one BHT entry.
// Async reset loads RESET_VAL.
module sat_counter2
  import mips_branch_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = BHT_WEAK_NT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  output logic [1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      if (up && q != BHT_STRONG_T) begin
        q <= q + 2'd1;
      end else if (!up && q != BHT_STRONG_NT) begin
        q <= q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with 2-bit BHT predictor,
// mispredict flush/redirect and saturating statistics.
module branch_resolve_predict
  import mips_branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input logic Clk,
  input logic Reset,
  branch_resolve_predict_if.slave bus
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  logic [IDXW-1:0]       fidx;
  logic [IDXW-1:0]       ridx;
  logic [1:0]            bht [BHT_DEPTH];
  logic [BHT_DEPTH-1:0]  hit;
  logic                  ev;
  logic                  taken;
  logic                  mis;
  logic                  eq;
  logic                  neg;
  logic                  zero;

  logic                  pcsrc_q;
  logic                  flush_q;
  logic [DATA_WIDTH-1:0] redir_q;
  logic [CNT_WIDTH-1:0]  bcnt_q;
  logic [CNT_WIDTH-1:0]  mcnt_q;

  assign fidx = bus.FetchPC[IDXW+1:2];
  assign ridx = bus.ResPC[IDXW+1:2];
  assign ev   = bus.ResValid & bus.Branch & ~bus.Stall;

  assign eq   = bus.OperandA == bus.OperandB;
  assign neg  = bus.OperandA[DATA_WIDTH-1];
  assign zero = bus.OperandA == '0;

  always_comb begin
    taken = 1'b0;
    unique case (bus.BranchOp)
      BR_BEQ:    taken = eq;
      BR_BNE:    taken = ~eq;
      BR_BLEZ:   taken = neg | zero;
      BR_BGTZ:   taken = ~neg & ~zero;
      BR_BLTZ:   taken = neg;
      BR_BGEZ:   taken = ~neg;
      BR_ALWAYS: taken = 1'b1;
      BR_NONE:   taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

  assign mis = taken != bus.ResPredTaken;
  assign hit = ev ? (BHT_DEPTH'(1) << ridx) : '0;

  // Lookup reads the registered entry, so a same-cycle
  // update to that index is seen only next cycle.
  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
    sat_counter2 #(
      .RESET_VAL (BHT_WEAK_NT)
    ) u_cnt (
      .clk (Clk),
      .rst (Reset),
      .en  (hit[i]),
      .up  (taken),
      .q   (bht[i])
    );
  end

  assign bus.PredTaken = bht[fidx][1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pcsrc_q <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= '0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      pcsrc_q <= ev & taken;
      flush_q <= ev & mis;
      if (ev) begin
        redir_q <= taken ? bus.ResTarget
                         : bus.ResPC + DATA_WIDTH'(4);
        if (bcnt_q != '1) begin
          bcnt_q <= bcnt_q + CNT_WIDTH'(1);
        end
        if (mis && mcnt_q != '1) begin
          mcnt_q <= mcnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.PCSrc        = pcsrc_q;
  assign bus.Flush        = flush_q;
  assign bus.RedirectPC   = redir_q;
  assign bus.BranchCount  = bcnt_q;
  assign bus.MispredCount = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: default
// instance plus a CNT_WIDTH=2 instance for saturation.
module tb_branch_resolve_predict;
  import mips_branch_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  branch_resolve_predict_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  branch_resolve_predict_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  branch_resolve_predict #(
    .DATA_WIDTH (32),
    .BHT_DEPTH  (64),
    .CNT_WIDTH  (16)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  branch_resolve_predict #(
    .DATA_WIDTH (32),
    .BHT_DEPTH  (64),
    .CNT_WIDTH  (2)
  ) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic [2:0] op,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] pc,
                    input logic [31:0] tgt,
                    input logic pt,
                    input logic st);
    bus.ResValid     = 1'b1;
    bus.Branch       = 1'b1;
    bus.BranchOp     = op;
    bus.OperandA     = a;
    bus.OperandB     = b;
    bus.ResPC        = pc;
    bus.ResTarget    = tgt;
    bus.ResPredTaken = pt;
    bus.Stall        = st;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    bus.ResValid  = 1'b0;
    bus.Branch    = 1'b0;
    bus.Stall     = 1'b0;
    bus2.ResValid = 1'b0;
    bus2.Branch   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.FetchPC = 32'h0;
    bus.ResValid = 1'b0;
    bus.Branch = 1'b0;
    bus.BranchOp = 3'd0;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.ResPC = '0;
    bus.ResTarget = '0;
    bus.ResPredTaken = 1'b0;
    bus.Stall = 1'b0;
    bus2.FetchPC = 32'h0;
    bus2.ResValid = 1'b0;
    bus2.Branch = 1'b0;
    bus2.BranchOp = BR_ALWAYS;
    bus2.OperandA = '0;
    bus2.OperandB = '0;
    bus2.ResPC = 32'h20;
    bus2.ResTarget = 32'h400;
    bus2.ResPredTaken = 1'b1;
    bus2.Stall = 1'b0;

    // reset then idle
    repeat (2) @(posedge Clk);
    #5;
    Reset = 1'b0;
    #1;
    check("rst_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("rst_flush", 32'(bus.Flush), 32'd0);
    check("rst_redir", bus.RedirectPC, 32'h0);
    check("rst_bcnt", 32'(bus.BranchCount), 32'd0);
    check("rst_mcnt", 32'(bus.MispredCount), 32'd0);
    check("rst_pred0", 32'(bus.PredTaken), 32'd0);
    bus.FetchPC = 32'hFC;
    #1;
    check("rst_predfc", 32'(bus.PredTaken), 32'd0);

    // BEQ taken, mispredicted
    br(BR_BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0, 1'b0);
    tick();
    check("beq_pcsrc", 32'(bus.PCSrc), 32'd1);
    check("beq_flush", 32'(bus.Flush), 32'd1);
    check("beq_redir", bus.RedirectPC, 32'h80);
    check("beq_mcnt", 32'(bus.MispredCount), 32'd1);
    check("beq_bcnt", 32'(bus.BranchCount), 32'd1);
    bus.FetchPC = 32'h40;
    #1;
    check("beq_pred40", 32'(bus.PredTaken), 32'd1);
    tick();
    check("idle_flush", 32'(bus.Flush), 32'd0);
    check("idle_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("idle_redir", bus.RedirectPC, 32'h80);

    // BNE not taken, predicted correctly; entry 0 -> 00
    br(BR_BNE, 32'd7, 32'd7, 32'h100, 32'h200, 1'b0, 1'b0);
    tick();
    check("bne_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("bne_flush", 32'(bus.Flush), 32'd0);
    check("bne_redir", bus.RedirectPC, 32'h104);
    check("bne_bcnt", 32'(bus.BranchCount), 32'd2);
    check("bne_mcnt", 32'(bus.MispredCount), 32'd1);
    // one taken from 00 lands on 01, still predicts not-taken
    br(BR_ALWAYS, 32'd0, 32'd0, 32'h100, 32'h300, 1'b0, 1'b0);
    tick();
    check("alw_redir", bus.RedirectPC, 32'h300);
    bus.FetchPC = 32'h100;
    #1;
    check("bne_entry00", 32'(bus.PredTaken), 32'd0);

    // signed compare modes
    br(BR_BLTZ, 32'hFFFFFFFF, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("bltz_m1", 32'(bus.PCSrc), 32'd1);
    br(BR_BGEZ, 32'hFFFFFFFF, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("bgez_m1", 32'(bus.PCSrc), 32'd0);
    check("bgez_redir", bus.RedirectPC, 32'h48);
    br(BR_BLEZ, 32'hFFFFFFFF, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("blez_m1", 32'(bus.PCSrc), 32'd1);
    br(BR_BGTZ, 32'hFFFFFFFF, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("bgtz_m1", 32'(bus.PCSrc), 32'd0);
    br(BR_BLEZ, 32'h0, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("blez_0", 32'(bus.PCSrc), 32'd1);
    check("blez_0_flush", 32'(bus.Flush), 32'd1);
    br(BR_BGTZ, 32'h0, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("bgtz_0", 32'(bus.PCSrc), 32'd0);
    br(BR_NONE, 32'h0, 32'd0, 32'h44, 32'h1000, 1'b0, 1'b0);
    tick();
    check("rsvd", 32'(bus.PCSrc), 32'd0);

    // ResPC+4 wraps
    br(BR_BEQ, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h1000, 1'b0, 1'b0);
    tick();
    check("wrap_redir", bus.RedirectPC, 32'h0);
    check("mid_bcnt", 32'(bus.BranchCount), 32'd11);
    check("mid_mcnt", 32'(bus.MispredCount), 32'd5);

    // saturation at index 2, then aliasing via 0x108
    for (int i = 0; i < 4; i++) begin
      br(BR_BEQ, 32'd0, 32'd0, 32'h8, 32'h500, 1'b1, 1'b0);
      tick();
    end
    br(BR_BNE, 32'd0, 32'd0, 32'h8, 32'h500, 1'b1, 1'b0);
    tick();
    check("sat_flush", 32'(bus.Flush), 32'd1);
    bus.FetchPC = 32'h8;
    #1;
    check("sat_pred8", 32'(bus.PredTaken), 32'd1);
    bus.FetchPC = 32'h108;
    #1;
    check("alias_pred", 32'(bus.PredTaken), 32'd1);
    // same-cycle lookup and update of index 2
    br(BR_BNE, 32'd0, 32'd0, 32'h8, 32'h500, 1'b1, 1'b0);
    #1;
    check("same_cyc_old", 32'(bus.PredTaken), 32'd1);
    tick();
    check("same_cyc_new", 32'(bus.PredTaken), 32'd0);
    check("sat_bcnt", 32'(bus.BranchCount), 32'd17);
    check("sat_mcnt", 32'(bus.MispredCount), 32'd7);

    // stalled resolve does nothing
    br(BR_BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0, 1'b1);
    tick();
    check("stall_flush", 32'(bus.Flush), 32'd0);
    check("stall_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("stall_bcnt", 32'(bus.BranchCount), 32'd17);
    check("stall_redir", bus.RedirectPC, 32'hC);

    // async reset during a flush
    br(BR_BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0, 1'b0);
    tick();
    check("pre_rst_flush", 32'(bus.Flush), 32'd1);
    bus.FetchPC = 32'h40;
    #1;
    check("pre_rst_pred", 32'(bus.PredTaken), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    check("arst_flush", 32'(bus.Flush), 32'd0);
    check("arst_pcsrc", 32'(bus.PCSrc), 32'd0);
    check("arst_bcnt", 32'(bus.BranchCount), 32'd0);
    check("arst_pred40", 32'(bus.PredTaken), 32'd0);
    bus.FetchPC = 32'h8;
    #1;
    check("arst_pred8", 32'(bus.PredTaken), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;

    // 2-bit statistics saturate
    for (int i = 0; i < 3; i++) begin
      bus2.ResValid = 1'b1;
      bus2.Branch = 1'b1;
      tick();
    end
    check("c2_bcnt3", 32'(bus2.BranchCount), 32'd3);
    for (int i = 0; i < 2; i++) begin
      bus2.ResValid = 1'b1;
      bus2.Branch = 1'b1;
      tick();
    end
    check("c2_bcnt5", 32'(bus2.BranchCount), 32'd3);
    check("c2_mcnt", 32'(bus2.MispredCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
